// File: rtl/usr_exec.sv
// Universal shift register with a command sequencer: one command per handshake, one shift step per clock.
// Latency: a command accepted at edge T0 with n steps has Q final after edge Tn, done high between Tn and Tn+1.
// Backpressure: cmd_ready is high only in IDLE; commands offered in EXEC or DONE are not consumed.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; S (select), L (load data), count (steps) sampled on acceptance
//   undo                  restore pre-command value (only with USR_UNDO_EN defined)
//   Q, carry, zero        register value, last bit shifted out, Q==0 flag
//   busy, done            high while stepping; one-cycle completion pulse
//
// Optional feature macro: USR_UNDO_EN builds the snapshot register and the undo path.
module usr_exec #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] L,
    input  logic [CNT_W-1:0] count,
    input  logic             undo,
    output logic [WIDTH-1:0] Q,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [2:0]       op;        // latched select
    logic [WIDTH-1:0] ld;        // latched load data
    logic [CNT_W-1:0] rem;       // steps still to apply
    logic [CNT_W-1:0] rem_init;
    logic             accept;
    logic             undo_go;

    logic [WIDTH-1:0] step_q;
    logic             step_out;

`ifdef USR_UNDO_EN
    logic [WIDTH-1:0] snap;
    logic             snap_vld;

    // undo blocks the handshake in the same cycle so it always wins over a command
    assign cmd_ready = (state == IDLE) && !undo;
    assign undo_go   = (state == IDLE) && undo && snap_vld;
`else
    logic unused_undo;

    assign unused_undo = undo;
    assign cmd_ready   = (state == IDLE);
    assign undo_go     = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;
    assign zero   = (Q == '0);

    // Load always takes exactly one step; hold takes none, so it goes straight to DONE.
    always_comb begin
        rem_init = count;
        if (S == 3'b111) begin
            rem_init = CNT_W'(1);
        end else if (S == 3'b000) begin
            rem_init = '0;
        end
    end

    // One step of the latched operation applied to the current Q.
    always_comb begin
        step_q   = Q;
        step_out = carry;
        case (op)
            3'b001: begin step_q = {Q[0], Q[WIDTH-1:1]};         step_out = Q[0];       end
            3'b010: begin step_q = {Q[WIDTH-2:0], Q[WIDTH-1]};   step_out = Q[WIDTH-1]; end
            3'b011: begin step_q = {1'b0, Q[WIDTH-1:1]};         step_out = Q[0];       end
            3'b100: begin step_q = {Q[WIDTH-2:0], 1'b0};         step_out = Q[WIDTH-1]; end
            3'b101: begin step_q = {Q[WIDTH-1], Q[WIDTH-1:1]};   step_out = Q[0];       end
            // arithmetic left keeps the sign bit and drops the bit below it
            3'b110: begin step_q = {Q[WIDTH-1], Q[WIDTH-3:0], 1'b0}; step_out = Q[WIDTH-2]; end
            3'b111: begin step_q = ld;                           step_out = carry;      end
            default: begin step_q = Q;                           step_out = carry;      end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (undo_go) begin
                    state_nxt = DONE;
                end else if (accept) begin
                    state_nxt = (rem_init == '0) ? DONE : EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                // rem==0 cannot occur here; treat it as finished rather than stalling
                if (rem <= CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q     <= '0;
            carry <= 1'b0;
            op    <= '0;
            ld    <= '0;
            rem   <= '0;
`ifdef USR_UNDO_EN
            snap     <= '0;
            snap_vld <= 1'b0;
`endif
        end else begin
`ifdef USR_UNDO_EN
            if (undo_go) begin
                Q        <= snap;
                carry    <= 1'b0;
                snap_vld <= 1'b0;
            end else if (accept) begin
                snap     <= Q;
                snap_vld <= 1'b1;
            end
`endif
            if (accept) begin
                op  <= S;
                ld  <= L;
                rem <= rem_init;
            end else if ((state == EXEC) && (rem != '0)) begin
                Q     <= step_q;
                carry <= step_out;
                rem   <= rem - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_usr_exec.sv
// Bench for usr_exec: directed command table, mid-run reset, optional undo sequence,
// and randomized commands checked against an arithmetic reference model.
module tb_usr_exec;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    S;
    logic [W-1:0]  L;
    logic [CW-1:0] count;
    logic          undo;
    logic [W-1:0]  Q;
    logic          carry;
    logic          zero;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int mq = 0;   // model register value
    int mc = 0;   // model carry

    usr_exec #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .S         (S),
        .L         (L),
        .count     (count),
        .undo      (undo),
        .Q         (Q),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: one command's effect computed with integer arithmetic on the model state.
    task automatic model_cmd(input int s, input int l, input int cnt, output int n);
        int msb;
        int mask;
        int sign;
        msb  = 1 << (W - 1);
        mask = (1 << W) - 1;
        if (s == 7) begin
            n  = 1;
            mq = l;
        end else begin
            n = (s == 0) ? 0 : cnt;
            for (int i = 0; i < n; i++) begin
                sign = mq & msb;
                case (s)
                    1: begin mc = mq & 1;                 mq = (mq >> 1) | (mc * msb); end
                    2: begin mc = (mq & msb) != 0;        mq = ((mq * 2) & mask) | mc; end
                    3: begin mc = mq & 1;                 mq = mq >> 1; end
                    4: begin mc = (mq & msb) != 0;        mq = (mq * 2) & mask; end
                    5: begin mc = mq & 1;                 mq = (mq >> 1) | sign; end
                    default: begin
                        mc = (mq & (msb >> 1)) != 0;
                        mq = ((mq * 2) & (msb - 1)) | sign;
                    end
                endcase
            end
        end
    endtask

    // Issue one command (called right after a falling edge) and check its whole life.
    // With noise set, a load of 0101 is kept on the inputs while the command runs.
    task automatic run_cmd(input int s, input int l, input int cnt, input bit noise, input string tag);
        int n;
        int busy_cnt;
        int lat;
        int k;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        S         = 3'(s);
        L         = W'(l);
        count     = CW'(cnt);
        @(posedge clk);
        #1;
        if (noise) begin
            S     = 3'b111;
            L     = 4'b0101;
            count = 2'd3;
        end else begin
            cmd_valid = 1'b0;
            S         = 3'($urandom_range(0, 7));
            L         = W'($urandom);
        end
        model_cmd(s, l, cnt, n);
        busy_cnt = 0;
        lat      = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk({tag, " done latency"}, lat, n);
        chk({tag, " busy cycles"}, busy_cnt, n);
        chk({tag, " Q"}, Q, mq);
        chk({tag, " carry"}, carry, mc);
        chk({tag, " zero"}, zero, (mq == 0) ? 1 : 0);
        @(negedge clk);
        chk({tag, " done width"}, done, 0);
        chk({tag, " ready after"}, cmd_ready, 1);
        chk({tag, " Q after"}, Q, mq);
    endtask

    typedef struct {
        logic [2:0]    s;
        logic [W-1:0]  l;
        logic [CW-1:0] cnt;
        bit            noise;
        logic [W-1:0]  eq;
        logic          ec;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Commands run back to back from reset; expected Q/carry after each
        vecs[0]  = '{3'b111, 4'b1011, 2'd3, 1'b0, 4'b1011, 1'b0}; // load, count ignored
        vecs[1]  = '{3'b001, 4'b0000, 2'd3, 1'b1, 4'b0111, 1'b0}; // CSR x3, ignored load offered
        vecs[2]  = '{3'b111, 4'b1000, 2'd0, 1'b0, 4'b1000, 1'b0}; // load with count 0 still one step
        vecs[3]  = '{3'b101, 4'b0000, 2'd2, 1'b0, 4'b1110, 1'b0}; // ASR x2
        vecs[4]  = '{3'b111, 4'b0111, 2'd1, 1'b0, 4'b0111, 1'b0}; // load
        vecs[5]  = '{3'b100, 4'b0000, 2'd3, 1'b0, 4'b1000, 1'b1}; // LSL x3
        vecs[6]  = '{3'b011, 4'b0000, 2'd0, 1'b0, 4'b1000, 1'b1}; // zero-step shift
        vecs[7]  = '{3'b000, 4'b1111, 2'd3, 1'b0, 4'b1000, 1'b1}; // hold
        vecs[8]  = '{3'b010, 4'b0000, 2'd1, 1'b0, 4'b0001, 1'b1}; // CSL x1
        vecs[9]  = '{3'b111, 4'b1011, 2'd2, 1'b0, 4'b1011, 1'b1}; // load keeps carry
        vecs[10] = '{3'b110, 4'b0000, 2'd2, 1'b0, 4'b1100, 1'b1}; // ASL x2 keeps sign

        reset     = 1'b1;
        cmd_valid = 1'b0;
        undo      = 1'b0;
        S         = '0;
        L         = '0;
        count     = '0;
        repeat (2) @(negedge clk);
        chk("reset Q", Q, 0);
        chk("reset carry", carry, 0);
        chk("reset zero", zero, 1);
        chk("reset ready", cmd_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_cmd(int'(vecs[i].s), int'(vecs[i].l), int'(vecs[i].cnt), vecs[i].noise, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table Q", i), Q, vecs[i].eq);
            chk($sformatf("vec%0d table carry", i), carry, vecs[i].ec);
        end

        // Reset during the second step of CSR x3
        run_cmd(7, 4'b1011, 0, 1'b0, "pre-reset load");
        cmd_valid = 1'b1;
        S         = 3'b001;
        count     = 2'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("csr before step1 busy", busy, 1);
        @(negedge clk);
        chk("csr step1 Q", Q, 4'b1101);
        #2 reset = 1'b1;
        #1;
        chk("midreset Q", Q, 0);
        chk("midreset carry", carry, 0);
        chk("midreset zero", zero, 1);
        chk("midreset ready", cmd_ready, 1);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        mq = 0;
        mc = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        begin
            int seen_done;
            int seen_busy;
            seen_done = 0;
            seen_busy = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                seen_done += int'(done);
                seen_busy += int'(busy);
            end
            chk("postreset no done", seen_done, 0);
            chk("postreset no busy", seen_busy, 0);
            chk("postreset Q", Q, 0);
        end

`ifdef USR_UNDO_EN
        run_cmd(7, 4'b1011, 0, 1'b0, "undo load");
        run_cmd(3, 0, 1, 1'b0, "undo lsr");
        chk("undo lsr Q", Q, 4'b0101);
        undo      = 1'b1;
        cmd_valid = 1'b1;
        S         = 3'b111;
        L         = 4'b0000;
        #1 chk("undo blocks ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        undo      = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("undo Q", Q, 4'b1011);
        chk("undo carry", carry, 0);
        chk("undo done", done, 1);
        mq = 11;
        mc = 0;
        @(negedge clk);
        chk("undo done width", done, 0);
        undo = 1'b1;
        @(posedge clk);
        #1 undo = 1'b0;
        @(negedge clk);
        chk("undo2 ignored done", done, 0);
        chk("undo2 ignored Q", Q, 4'b1011);
        @(negedge clk);
`endif

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
